// File: rtl/shift_reg_pkg.sv
// Shared definitions for the universal shift register: mode encodings and
// the shift counter width derivation.
package shift_reg_pkg;

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SHR  = 2'b01;
    localparam logic [1:0] MODE_SHL  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    // Counter must hold values 0..width inclusive, hence one extra bit.
    function automatic int calc_cw(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/dff_en_cell.sv
// Single-bit enable-gated D flip-flop with async active-high reset to 0.
module dff_en_cell (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic d,
    output logic q,
    output logic qbar
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= 1'b0;
        end else if (en) begin
            q <= d;
        end
    end

    assign qbar = ~q;

endmodule

// File: rtl/univ_shift_reg.sv
// WIDTH-bit universal shift register (hold/shift right/shift left/load) built
// from dff_en_cell bit cells, with a saturating shift counter.
module univ_shift_reg
    import shift_reg_pkg::*;
#(
    parameter  int WIDTH = 4,
    localparam int CW    = calc_cw(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             sin_r,
    input  logic             sin_l,
    input  logic [WIDTH-1:0] pdata,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    output logic             sout_r,
    output logic             sout_l,
    output logic [CW-1:0]    shift_cnt,
    output logic             word_done
);

    logic [WIDTH-1:0] shr_vec;
    logic [WIDTH-1:0] shl_vec;
    logic [WIDTH-1:0] next_q;

    assign shr_vec = {sin_r, q[WIDTH-1:1]};
    assign shl_vec = {q[WIDTH-2:0], sin_l};

    // Per-bit 4:1 next-value mux feeding each enable-gated cell.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        always_comb begin
            next_q[i] = q[i];
            case (mode)
                MODE_HOLD: next_q[i] = q[i];
                MODE_SHR:  next_q[i] = shr_vec[i];
                MODE_SHL:  next_q[i] = shl_vec[i];
                MODE_LOAD: next_q[i] = pdata[i];
                default:   next_q[i] = q[i];
            endcase
        end

        dff_en_cell u_cell (
            .clk  (clk),
            .rst  (rst),
            .en   (en),
            .d    (next_q[i]),
            .q    (q[i]),
            .qbar (qbar[i])
        );
    end

    // Shift counter: cleared by load, saturates at WIDTH so word_done latches
    // until the next load or reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_cnt <= '0;
        end else if (en) begin
            case (mode)
                MODE_LOAD: shift_cnt <= '0;
                MODE_SHR, MODE_SHL: begin
                    if (shift_cnt != CW'(WIDTH)) begin
                        shift_cnt <= shift_cnt + 1'b1;
                    end
                end
                default: shift_cnt <= shift_cnt;
            endcase
        end
    end

    assign word_done = (shift_cnt == CW'(WIDTH));
    assign sout_r    = q[0];
    assign sout_l    = q[WIDTH-1];

endmodule

// File: tb/tb_univ_shift_reg.sv
// Self-checking bench for univ_shift_reg: directed scenarios plus randomized
// stimulus compared against an arithmetic reference model.
module tb_univ_shift_reg;

    localparam int W    = 4;
    localparam int CW   = 3;
    localparam int MASK = (1 << W) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          en = 1'b0;
    logic [1:0]    mode = 2'b00;
    logic          sin_r = 1'b0;
    logic          sin_l = 1'b0;
    logic [W-1:0]  pdata = '0;
    logic [W-1:0]  q;
    logic [W-1:0]  qbar;
    logic          sout_r;
    logic          sout_l;
    logic [CW-1:0] shift_cnt;
    logic          word_done;

    int checkCount = 0;
    int passCount  = 0;
    int modelQ     = 0;
    int modelCnt   = 0;

    univ_shift_reg #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .mode      (mode),
        .sin_r     (sin_r),
        .sin_l     (sin_l),
        .pdata     (pdata),
        .q         (q),
        .qbar      (qbar),
        .sout_r    (sout_r),
        .sout_l    (sout_l),
        .shift_cnt (shift_cnt),
        .word_done (word_done)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checkCount++;
        if (observed == expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, observed, expected, $time);
        end
    endtask

    // Reference behaviour expressed as plain integer arithmetic.
    task automatic modelStep(input int e, input int m, input int sr, input int sl, input int pd);
        if (e != 0) begin
            case (m)
                1: begin
                    modelQ   = (modelQ >> 1) | (sr << (W - 1));
                    modelCnt = (modelCnt + 1 > W) ? W : modelCnt + 1;
                end
                2: begin
                    modelQ   = ((modelQ << 1) | sl) & MASK;
                    modelCnt = (modelCnt + 1 > W) ? W : modelCnt + 1;
                end
                3: begin
                    modelQ   = pd;
                    modelCnt = 0;
                end
                default: ;
            endcase
        end
    endtask

    task automatic checkAll(input string tag);
        checkOutput({tag, ".q"}, int'(q), modelQ);
        checkOutput({tag, ".qbar"}, int'(qbar), (~modelQ) & MASK);
        checkOutput({tag, ".sout_r"}, int'(sout_r), modelQ & 1);
        checkOutput({tag, ".sout_l"}, int'(sout_l), (modelQ >> (W - 1)) & 1);
        checkOutput({tag, ".cnt"}, int'(shift_cnt), modelCnt);
        checkOutput({tag, ".done"}, int'(word_done), (modelCnt == W) ? 1 : 0);
    endtask

    // Drives one cycle's inputs, clocks them in and advances the model.
    task automatic applyStimulus(input logic e, input logic [1:0] m, input logic sr,
                                 input logic sl, input logic [W-1:0] pd);
        en    = e;
        mode  = m;
        sin_r = sr;
        sin_l = sl;
        pdata = pd;
        @(posedge clk);
        modelStep(int'(e), int'(m), int'(sr), int'(sl), int'(pd));
        #1;
    endtask

    task automatic pulseReset();
        #2 rst = 1'b1;
        #1;
        modelQ   = 0;
        modelCnt = 0;
        checkAll("async_rst");
        checkOutput("async_rst.q_const", int'(q), 0);
        checkOutput("async_rst.qbar_const", int'(qbar), 15);
        #1 rst = 1'b0;
    endtask

    initial begin
        logic [3:0] shlExp [6];
        logic [3:0] soutExp;
        shlExp  = '{4'b0011, 4'b0111, 4'b1111, 4'b1111, 4'b1111, 4'b1111};
        soutExp = 4'b1011;

        rst = 1'b1;
        #12 rst = 1'b0;
        @(negedge clk);
        checkAll("reset");

        // Async reset mid-cycle with q=4'hA
        applyStimulus(1'b1, 2'b11, 1'b0, 1'b0, 4'hA);
        checkOutput("load_A", int'(q), 10);
        pulseReset();

        // Load then hold
        applyStimulus(1'b1, 2'b11, 1'b0, 1'b0, 4'b1011);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 2'b00, 1'b1, 1'b1, 4'h0);
            checkOutput("hold.q", int'(q), 11);
            checkOutput("hold.qbar", int'(qbar), 4);
            checkOutput("hold.cnt", int'(shift_cnt), 0);
        end

        // Shift right a full word
        applyStimulus(1'b1, 2'b11, 1'b0, 1'b0, 4'b1011);
        for (int i = 0; i < 4; i++) begin
            checkOutput("shr.sout_r", int'(sout_r), int'(soutExp[i]));
            applyStimulus(1'b1, 2'b01, 1'b0, 1'b0, 4'h0);
            checkAll("shr");
        end
        checkOutput("shr.q_end", int'(q), 0);
        checkOutput("shr.done", int'(word_done), 1);

        // Shift left with saturation
        applyStimulus(1'b1, 2'b11, 1'b0, 1'b0, 4'b0001);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, 2'b10, 1'b0, 1'b1, 4'h0);
            checkOutput("shl.q", int'(q), int'(shlExp[i]));
            checkOutput("shl.cnt", int'(shift_cnt), (i + 1 > 4) ? 4 : i + 1);
        end

        // Load clears word_done
        applyStimulus(1'b1, 2'b11, 1'b0, 1'b0, 4'h5);
        checkOutput("reload.q", int'(q), 5);
        checkOutput("reload.done", int'(word_done), 0);

        // Enable gating
        applyStimulus(1'b1, 2'b11, 1'b0, 1'b0, 4'b0110);
        applyStimulus(1'b1, 2'b01, 1'b0, 1'b0, 4'h0);
        applyStimulus(1'b1, 2'b10, 1'b0, 1'b0, 4'h0);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b0, 2'b11, 1'b1, 1'b1, 4'hF);
            checkOutput("engate.q", int'(q), 6);
            checkOutput("engate.cnt", int'(shift_cnt), 2);
        end
        applyStimulus(1'b1, 2'b11, 1'b0, 1'b0, 4'hF);
        checkOutput("engate.q_after", int'(q), 15);
        checkOutput("engate.cnt_after", int'(shift_cnt), 0);

        // Randomized traffic, with occasional mid-cycle resets
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 7) != 0), 2'($urandom_range(0, 3)),
                          1'($urandom), 1'($urandom), 4'($urandom));
            checkAll("rand");
            if ($urandom_range(0, 49) == 0) begin
                pulseReset();
            end
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
